// File: rtl/gf_pkg.sv
// Shared types and helpers for the GF(2^m) inverter.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } gf_inv_state_t;

  // Clocks from the accepting edge until out_valid rises.
  function automatic int unsigned gf_inv_latency(input int unsigned mm);
    return 2 * (mm - 1);
  endfunction

endpackage

// File: rtl/gf_2m_mult.sv
// Combinational GF(2^m) multiplier, polynomial basis, MSB-first shift-and-add.
module gf_2m_mult #(
  parameter int unsigned m = 4
) (
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  input  logic [m-1:0] p,
  output logic [m-1:0] y
);

  logic [m-1:0] r;

  // Horner: r = r*x mod P, then add a when the current bit of b is set.
  always_comb begin
    r = '0;
    for (int unsigned i = 0; i < m; i++) begin
      r = {r[m-2:0], 1'b0} ^ (r[m-1] ? p : '0) ^ (b[m-1-i] ? a : '0);
    end
    y = r;
  end

endmodule

// File: rtl/gf_2m_inv.sv
// Sequential GF(2^m) inverter: y = a^(2^m-2) by square-and-multiply on one
// shared multiplier, with valid/ready handshakes on both sides.
module gf_2m_inv
  import gf_pkg::*;
#(
  parameter int unsigned m = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [m-1:0] a,
  input  logic [m-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [m-1:0] y,
  output logic         zero_in
);

  localparam int unsigned cw = $clog2(m);

  gf_inv_state_t state, state_nx;

  logic [m-1:0]  p_r;
  logic [m-1:0]  sq;
  logic [m-1:0]  acc;
  logic [cw-1:0] cnt;
  logic          z_r;
  logic [m-1:0]  mul_a;
  logic [m-1:0]  prod;
  logic          accept;
  logic [5:0]    lat;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign y         = out_valid ? acc : '0;
  assign zero_in   = out_valid && z_r;

  // SQR squares sq; MUL folds sq into the running product.
  assign mul_a = (state == MUL) ? acc : sq;

  gf_2m_mult #(.m(m)) u_mult (
    .a (mul_a),
    .b (sq),
    .p (p_r),
    .y (prod)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = SQR;
      SQR:  state_nx = MUL;
      MUL:  state_nx = (cnt == cw'(1)) ? DONE : SQR;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sq    <= '0;
      acc   <= '0;
      cnt   <= '0;
      p_r   <= '0;
      z_r   <= 1'b0;
      lat   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            sq  <= a;
            acc <= {{(m-1){1'b0}}, 1'b1};
            cnt <= cw'(m - 1);
            p_r <= p;
            z_r <= (a == '0);
            lat <= '0;
          end
        end
        SQR: begin
          sq  <= prod;
          lat <= lat + 6'd1;
        end
        MUL: begin
          acc <= prod;
          cnt <= cnt - cw'(1);
          lat <= lat + 6'd1;
          if (cnt == cw'(1))
            assert (lat == 6'(gf_inv_latency(m) - 1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_2m_inv.sv
// Self-checking bench for gf_2m_inv at m=4 and m=8 against a brute-force
// field-inverse reference model.
module tb_gf_2m_inv;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv4, ir4, ov4, or4, z4;
  logic [3:0] a4, p4, y4;
  logic       iv8, ir8, ov8, or8, z8;
  logic [7:0] a8, p8, y8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gf_2m_inv #(.m(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .p(p4),
    .out_valid(ov4), .out_ready(or4), .y(y4), .zero_in(z4)
  );

  gf_2m_inv #(.m(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .p(p8),
    .out_valid(ov8), .out_ready(or8), .y(y8), .zero_in(z8)
  );

  // Carry-less product followed by long division by the full polynomial.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] w,
                                         input logic [7:0] pp, input int mm);
    logic [15:0] prod;
    logic [15:0] poly;
    prod = '0;
    poly = (16'd1 << mm) | {8'd0, pp};
    for (int i = 0; i < 8; i++)
      if (w[i]) prod = prod ^ ({8'd0, x} << i);
    for (int i = 15; i >= mm; i--)
      if (prod[i]) prod = prod ^ (poly << (i - mm));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] x, input logic [7:0] pp, input int mm);
    if (x == 8'd0) return 8'd0;
    for (int c = 1; c < (1 << mm); c++)
      if (ref_mul(x, 8'(c), pp, mm) == 8'd1) return 8'(c);
    return 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operand with out_ready high; returns result and edges to out_valid.
  task automatic run_op(input bit w8, input logic [7:0] av, output logic [7:0] yv,
                        output logic zv, output int lat);
    chk(w8 ? "rdy8" : "rdy4", {31'd0, w8 ? ir8 : ir4}, 32'd1);
    if (w8) begin a8 = av; iv8 = 1'b1; end
    else    begin a4 = av[3:0]; iv4 = 1'b1; end
    @(posedge clk); #1;
    iv4 = 1'b0; iv8 = 1'b0;
    lat = 0;
    while (((w8 ? ov8 : ov4) == 1'b0) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    yv = w8 ? y8 : {4'h0, y4};
    zv = w8 ? z8 : z4;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] yv, av, ev;
    logic       zv;
    int         lat;

    rst = 1'b1;
    iv4 = 1'b0; a4 = '0; p4 = 4'b0011; or4 = 1'b1;
    iv8 = 1'b0; a8 = '0; p8 = 8'h1B;   or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir4", {31'd0, ir4}, 1);
    chk("rst_ov4", {31'd0, ov4}, 0);
    chk("rst_y4",  {28'd0, y4}, 0);
    chk("rst_z4",  {31'd0, z4}, 0);
    chk("rst_ir8", {31'd0, ir8}, 1);
    chk("rst_ov8", {31'd0, ov8}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic m=4 case
    run_op(1'b0, 8'h02, yv, zv, lat);
    chk("inv2_y", {24'd0, yv}, 32'h9);
    chk("inv2_z", {31'd0, zv}, 0);
    chk("inv2_lat", lat, 6);

    // Exhaustive nonzero sweep, m=4, x^4+x+1
    for (int i = 1; i < 16; i++) begin
      av = 8'(i);
      run_op(1'b0, av, yv, zv, lat);
      chk("sweep_y", {24'd0, yv}, {24'd0, ref_inv(av, 8'h03, 4)});
      chk("sweep_prod", {24'd0, ref_mul(av, yv, 8'h03, 4)}, 1);
      chk("sweep_lat", lat, 6);
    end

    // Other irreducible polynomial, x^4+x^3+1, random operands
    p4 = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      av = 8'($urandom_range(1, 15));
      run_op(1'b0, av, yv, zv, lat);
      chk("p9_y", {24'd0, yv}, {24'd0, ref_inv(av, 8'h09, 4)});
    end
    p4 = 4'b0011;

    run_op(1'b0, 8'h00, yv, zv, lat);
    chk("zero4_y", {24'd0, yv}, 0);
    chk("zero4_z", {31'd0, zv}, 1);

    // m=8, AES polynomial
    run_op(1'b1, 8'h53, yv, zv, lat);
    chk("aes53_y", {24'd0, yv}, 32'hCA);
    chk("aes53_lat", lat, 14);
    run_op(1'b1, 8'h00, yv, zv, lat);
    chk("zero8_y", {24'd0, yv}, 0);
    chk("zero8_z", {31'd0, zv}, 1);
    for (int i = 0; i < 8; i++) begin
      av = 8'($urandom_range(1, 255));
      ev = ref_inv(av, 8'h1B, 8);
      run_op(1'b1, av, yv, zv, lat);
      chk("rand8_y", {24'd0, yv}, {24'd0, ev});
      chk("rand8_z", {31'd0, zv}, 0);
      chk("rand8_lat", lat, 14);
    end

    // Backpressure: result held, new input ignored while in DONE
    or4 = 1'b0;
    a4 = 4'h2; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", lat, 6);
    a4 = 4'h5; iv4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_y", {28'd0, y4}, 32'h9);
      chk("bp_ov", {31'd0, ov4}, 1);
      chk("bp_ir", {31'd0, ir4}, 0);
      @(posedge clk); #1;
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ir", {31'd0, ir4}, 1);
    chk("bp_rel_ov", {31'd0, ov4}, 0);
    chk("bp_rel_y", {28'd0, y4}, 0);
    iv4 = 1'b0;
    @(posedge clk); #1;
    chk("bp_idle_ir", {31'd0, ir4}, 1);

    // Reset in the middle of an operation
    a4 = 4'h7; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; iv4 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv4 = 1'b0;
    chk("mid_rst_ir", {31'd0, ir4}, 1);
    chk("mid_rst_ov", {31'd0, ov4}, 0);
    chk("mid_rst_y", {28'd0, y4}, 0);
    run_op(1'b0, 8'h02, yv, zv, lat);
    chk("post_rst_y", {24'd0, yv}, 32'h9);
    chk("post_rst_lat", lat, 6);

    // Back-to-back with in_valid held high
    a4 = 4'h2; iv4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'h3;
    lat = 0;
    while (!ov4 && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("b2b1_y", {28'd0, y4}, 32'h9);
    chk("b2b1_lat", lat, 6);
    @(posedge clk); #1;
    chk("b2b_idle", {31'd0, ir4}, 1);
    @(posedge clk); #1;
    chk("b2b_busy", {31'd0, ir4}, 0);
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 64) begin @(posedge clk); #1; lat++; end
    chk("b2b2_y", {28'd0, y4}, 32'hE);
    chk("b2b2_lat", lat, 6);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
